// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch address generator.
// Priority redirect (flush > branch > held branch > +step).
module pc_gen #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          INST_BYTES   = 4,
  parameter int          STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  new_pc_i,
  output logic               ce,
  output logic [ADDR_W-1:0]  pc,
  output logic               pend_valid_o,
  output logic               pc_misaligned_o
);

  localparam logic [ADDR_W-1:0] RV   = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_BOOT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] nxt_pc;
  logic [ADDR_W-1:0] nxt_pa;
  logic              nxt_pv;
  logic              unused_stall;

  assign unused_stall = ^stall;

  // Next-PC selection; a branch seen while stalled is parked.
  always_comb begin
    nxt_pc = pc;
    nxt_pa = pend_addr;
    nxt_pv = pend_valid_o;
    priority case (1'b1)
      flush_i: begin
        nxt_pc = new_pc_i;
        nxt_pv = 1'b0;
      end
      stall[0] && branch_flag_i: begin
        nxt_pa = branch_target_address_i;
        nxt_pv = 1'b1;
      end
      stall[0]: begin
      end
      branch_flag_i: begin
        nxt_pc = branch_target_address_i;
        nxt_pv = 1'b0;
      end
      pend_valid_o: begin
        nxt_pc = pend_addr;
        nxt_pv = 1'b0;
      end
      default: nxt_pc = pc + STEP;
    endcase
  end

  // Reset/boot sequencing and registered fetch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_RESET;
      ce              <= 1'b0;
      pc              <= RV;
      pend_addr       <= '0;
      pend_valid_o    <= 1'b0;
      pc_misaligned_o <= 1'b0;
    end else begin
      unique case (state)
        S_RESET: begin
          state <= S_BOOT;
          ce    <= 1'b1;
        end
        S_BOOT, S_RUN: begin
          state           <= S_RUN;
          ce              <= 1'b1;
          pc              <= nxt_pc;
          pend_addr       <= nxt_pa;
          pend_valid_o    <= nxt_pv;
          pc_misaligned_o <= |(nxt_pc & MASK);
        end
        default: begin
          state <= S_RESET;
          ce    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector bench for pc_gen.
// Second instance boots near the top of memory to show wrap.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] bt;
  logic        fl;
  logic [31:0] npc;

  logic        ce0, pv0, mis0;
  logic [31:0] pc0;
  logic        ce1, pv1, mis1;
  logic [31:0] pc1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_gen u0 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(br),
    .branch_target_address_i(bt),
    .flush_i(fl), .new_pc_i(npc),
    .ce(ce0), .pc(pc0),
    .pend_valid_o(pv0),
    .pc_misaligned_o(mis0)
  );

  pc_gen #(.RESET_VECTOR(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(br),
    .branch_target_address_i(bt),
    .flush_i(fl), .new_pc_i(npc),
    .ce(ce1), .pc(pc1),
    .pend_valid_o(pv1),
    .pc_misaligned_o(mis1)
  );

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        f;
    logic [31:0] n;
    logic        ce;
    logic [31:0] pc;
    logic        pv;
    logic        mis;
  } vec_t;

  vec_t vq[$];
  logic [31:0] wrap_exp [4];

  task automatic add(
    input logic r, input logic s, input logic b,
    input logic [31:0] t, input logic f,
    input logic [31:0] n, input logic c,
    input logic [31:0] p, input logic v,
    input logic m);
    vec_t e;
    e.r = r; e.s = s; e.b = b; e.t = t;
    e.f = f; e.n = n; e.ce = c; e.pc = p;
    e.pv = v; e.mis = m;
    vq.push_back(e);
  endtask

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h want %h",
                  nm, idx, act, exp);
  endtask

  initial begin
    rst = 1'b1; stall = '0; br = 1'b0;
    bt = '0; fl = 1'b0; npc = '0;

    //   r  s  b  tgt     f  npc     ce pc      pv m
    add(1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 0);
    add(1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 0);
    add(1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h4,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h8,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'hC,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h10, 0, 0);
    add(0, 1, 1, 32'h200, 0, 32'h0,  1, 32'h10, 1, 0);
    add(0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h10, 1, 0);
    add(0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h10, 1, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h200,0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h204,0, 0);
    add(0, 1, 1, 32'h200, 0, 32'h0,  1, 32'h204,1, 0);
    add(0, 1, 1, 32'h300, 0, 32'h0,  1, 32'h204,1, 0);
    add(0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h204,1, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h300,0, 0);
    add(0, 1, 1, 32'h200, 0, 32'h0,  1, 32'h300,1, 0);
    add(0, 1, 0, 32'h0,   1, 32'h180,1, 32'h180,0, 0);
    add(0, 1, 1, 32'h200, 0, 32'h0,  1, 32'h180,1, 0);
    add(0, 1, 1, 32'h240, 1, 32'h180,1, 32'h180,0, 0);
    add(0, 0, 1, 32'h102, 0, 32'h0,  1, 32'h102,0, 1);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h106,0, 1);
    add(0, 0, 0, 32'h0,   1, 32'h80, 1, 32'h80, 0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h84, 0, 0);
    add(0, 1, 1, 32'h400, 0, 32'h0,  1, 32'h84, 1, 0);
    add(1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,   1, 32'h500,1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h4,  0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h8,  0, 0);
    add(0, 1, 1, 32'h600, 0, 32'h0,  1, 32'h8,  1, 0);
    add(0, 0, 1, 32'h700, 0, 32'h0,  1, 32'h700,0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h704,0, 0);

    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    @(negedge clk);
    foreach (vq[i]) begin
      rst   = vq[i].r;
      stall = {5'($urandom), vq[i].s};
      br    = vq[i].b;
      bt    = vq[i].t;
      fl    = vq[i].f;
      npc   = vq[i].n;
      @(posedge clk);
      #1;
      chk("ce",  i, 32'(ce0),  32'(vq[i].ce));
      chk("pc",  i, pc0,       vq[i].pc);
      chk("pend",i, 32'(pv0),  32'(vq[i].pv));
      chk("mis", i, 32'(mis0), 32'(vq[i].mis));
      if (i >= 3 && i <= 6)
        chk("wrap_pc", i, pc1, wrap_exp[i-3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
